// File: rtl/cpu_pkg.sv
// Shared constants and types for the PC / return-stack unit.
// Widths, stack geometry, flush length and restart-vector formation.
package cpu_pkg;

    localparam int ADDR_W      = 14;
    localparam int STACK_DEPTH = 8;
    localparam int FLUSH_LEN   = 3;
    localparam int PTR_W       = $clog2(STACK_DEPTH);
    localparam int FCNT_W      = $clog2(FLUSH_LEN + 1);
    localparam int RSTV_SHIFT  = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Restart vector n lives at {8'b0, n, 3'b000}
    function automatic addr_t rstv_vec(input logic [2:0] n);
        return addr_t'(n) << RSTV_SHIFT;
    endfunction

endpackage

// File: rtl/cpu_pc_stack.sv
// Program counter held on top of an 8-entry circular return stack,
// with redirect flush sequencing, halt/wake and sticky stack errors.
module cpu_pc_stack
    import cpu_pkg::*;
(
    input  logic              CLK_I,
    input  logic              nRST_I,
    input  logic              STALL_I,
    input  logic              JMP_I,
    input  logic              CALL_I,
    input  logic              RET_I,
    input  logic              RSTV_I,
    input  logic [2:0]        RSTV_N_I,
    input  logic [ADDR_W-1:0] TARGET_I,
    input  logic [ADDR_W-1:0] RET_ADDR_I,
    input  logic              HALT_I,
    input  logic              WAKE_I,
    input  logic              CLR_ERR_I,
    output logic [ADDR_W-1:0] PC_O,
    output logic              FLUSH_O,
    output logic [2:0]        DEPTH_O,
    output logic              HALTED_O,
    output logic              OVF_O,
    output logic              UNF_O
);

    localparam logic [2:0]        DEPTH_MAX = 3'(STACK_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FCNT_LD   = FCNT_W'(FLUSH_LEN);

    state_t            state;
    state_t            state_n;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_n;
    addr_t             stk [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_up;
    logic [2:0]        depth;
    logic              ovf;
    logic              unf;

    logic  active;
    logic  do_rstv;
    logic  do_call;
    logic  do_ret;
    logic  do_jmp;
    logic  do_push;
    logic  redir;
    logic  do_inc;
    addr_t push_tgt;

    // Fixed-priority request selection; everything is masked in HALT
    always_comb begin
        active   = (state != ST_HALT);
        do_rstv  = active & RSTV_I;
        do_call  = active & ~RSTV_I & CALL_I;
        do_ret   = active & ~RSTV_I & ~CALL_I & RET_I;
        do_jmp   = active & ~RSTV_I & ~CALL_I & ~RET_I & JMP_I;
        do_push  = do_rstv | do_call;
        redir    = do_push | do_ret | do_jmp;
        do_inc   = active & ~redir & ~STALL_I & ~HALT_I;
        push_tgt = do_rstv ? rstv_vec(RSTV_N_I) : TARGET_I;
        ptr_up   = ptr + PTR_W'(1);
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        unique case (state)
            ST_RUN, ST_FLUSH: begin
                if (redir) begin
                    state_n = ST_FLUSH;
                    fcnt_n  = FCNT_LD;
                end else if (HALT_I) begin
                    state_n = ST_HALT;
                    fcnt_n  = '0;
                end else if (state == ST_FLUSH) begin
                    if (fcnt <= FCNT_W'(1)) begin
                        state_n = ST_RUN;
                        fcnt_n  = '0;
                    end else begin
                        fcnt_n = fcnt - FCNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (WAKE_I && !HALT_I) begin
                    state_n = ST_FLUSH;
                    fcnt_n  = FCNT_LD;
                end
            end
            default: begin
                state_n = ST_RUN;
                fcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk[i] <= '0;
            end
            ptr   <= '0;
            depth <= '0;
        end else if (do_push) begin
            stk[ptr]    <= RET_ADDR_I;
            stk[ptr_up] <= push_tgt;
            ptr         <= ptr_up;
            if (depth != DEPTH_MAX) begin
                depth <= depth + 3'd1;
            end
        end else if (do_ret) begin
            ptr <= ptr - PTR_W'(1);
            if (depth != 3'd0) begin
                depth <= depth - 3'd1;
            end
        end else if (do_jmp) begin
            stk[ptr] <= TARGET_I;
        end else if (do_inc) begin
            stk[ptr] <= stk[ptr] + ADDR_W'(1);
        end
    end

    // A new error in the same cycle beats the clear
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (do_push && depth == DEPTH_MAX) begin
                ovf <= 1'b1;
            end else if (CLR_ERR_I) begin
                ovf <= 1'b0;
            end
            if (do_ret && depth == 3'd0) begin
                unf <= 1'b1;
            end else if (CLR_ERR_I) begin
                unf <= 1'b0;
            end
        end
    end

    assign PC_O     = stk[ptr];
    assign DEPTH_O  = depth;
    assign FLUSH_O  = (state == ST_FLUSH);
    assign HALTED_O = (state == ST_HALT);
    assign OVF_O    = ovf;
    assign UNF_O    = unf;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// Directed bench for cpu_pc_stack: expectations are queued with the
// cycle they fall due, a monitor pops and compares them.
module tb_cpu_pc_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, jmp, call, ret, rstv, halt, wake, clr;
    logic [2:0]  rstv_n;
    logic [13:0] target, ret_addr;
    logic [13:0] pc;
    logic        flush, halted, ovf, unf;
    logic [2:0]  depth;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          due;
        string       nm;
        logic [13:0] pc;
        logic [2:0]  dep;
        logic        fl;
        logic        hl;
        logic        ov;
        logic        un;
    } exp_t;

    exp_t q[$];
    event chk_now;

    cpu_pc_stack dut (
        .CLK_I      (clk),
        .nRST_I     (rst_n),
        .STALL_I    (stall),
        .JMP_I      (jmp),
        .CALL_I     (call),
        .RET_I      (ret),
        .RSTV_I     (rstv),
        .RSTV_N_I   (rstv_n),
        .TARGET_I   (target),
        .RET_ADDR_I (ret_addr),
        .HALT_I     (halt),
        .WAKE_I     (wake),
        .CLR_ERR_I  (clr),
        .PC_O       (pc),
        .FLUSH_O    (flush),
        .DEPTH_O    (depth),
        .HALTED_O   (halted),
        .OVF_O      (ovf),
        .UNF_O      (unf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle();
        stall = 0; jmp = 0; call = 0; ret = 0; rstv = 0;
        halt = 0; wake = 0; clr = 0;
        rstv_n = '0; target = '0; ret_addr = '0;
    endtask

    task automatic push_exp(input int due, input string nm,
                            input logic [13:0] p, input logic [2:0] d,
                            input logic f, input logic h,
                            input logic o, input logic u);
        exp_t e;
        e.due = due; e.nm = nm; e.pc = p; e.dep = d;
        e.fl = f; e.hl = h; e.ov = o; e.un = u;
        q.push_back(e);
    endtask

    // Inputs are already set; expectation applies after the next edge
    task automatic step(input string nm,
                        input logic [13:0] p, input logic [2:0] d,
                        input logic f, input logic h,
                        input logic o, input logic u);
        push_exp(cyc + 1, nm, p, d, f, h, o, u);
        @(negedge clk);
        idle();
    endtask

    task automatic check_now(input string nm,
                             input logic [13:0] p, input logic [2:0] d,
                             input logic f, input logic h,
                             input logic o, input logic u);
        #1;
        push_exp(cyc, nm, p, d, f, h, o, u);
        ->chk_now;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_vec++;
                if (pc !== e.pc || depth !== e.dep || flush !== e.fl ||
                    halted !== e.hl || ovf !== e.ov || unf !== e.un) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h dep=%0d fl=%b hl=%b ov=%b un=%b want pc=%h dep=%0d fl=%b hl=%b ov=%b un=%b",
                             e.nm, pc, depth, flush, halted, ovf, unf,
                             e.pc, e.dep, e.fl, e.hl, e.ov, e.un);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset", 14'h0000, 0, 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        check_now("release", 14'h0000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step("free_run", 14'(i), 0, 0, 0, 0, 0);
        end

        // Call / return round trip
        jmp = 1; target = 14'h0010;
        step("jmp_0010", 14'h0010, 0, 1, 0, 0, 0);
        call = 1; target = 14'h0200; ret_addr = 14'h000E;
        step("call", 14'h0200, 1, 1, 0, 0, 0);
        step("call_fl2", 14'h0201, 1, 1, 0, 0, 0);
        step("call_fl3", 14'h0202, 1, 1, 0, 0, 0);
        step("call_run", 14'h0203, 1, 0, 0, 0, 0);
        ret = 1;
        step("ret", 14'h000E, 0, 1, 0, 0, 0);
        step("ret_fl2", 14'h000F, 0, 1, 0, 0, 0);
        step("ret_fl3", 14'h0010, 0, 1, 0, 0, 0);
        step("ret_run", 14'h0011, 0, 0, 0, 0, 0);

        // RSTV beats JMP
        rstv = 1; rstv_n = 3'd5; jmp = 1; target = 14'h1234;
        ret_addr = 14'h0100;
        step("rstv5", 14'h0028, 1, 1, 0, 0, 0);
        ret = 1;
        step("rstv_ret", 14'h0100, 0, 1, 0, 0, 0);
        step("rstv_fl2", 14'h0101, 0, 1, 0, 0, 0);
        step("rstv_fl3", 14'h0102, 0, 1, 0, 0, 0);
        step("rstv_run", 14'h0103, 0, 0, 0, 0, 0);

        // Overflow then underflow
        for (int i = 0; i < 8; i++) begin
            call = 1; target = 14'h1000 + 14'(i);
            ret_addr = 14'h0500 + 14'(i);
            step("call_n", 14'h1000 + 14'(i), 3'((i < 7) ? i + 1 : 7),
                 1, 0, (i == 7), 0);
        end
        for (int k = 1; k <= 8; k++) begin
            ret = 1;
            step("ret_n", (k < 8) ? 14'h0500 + 14'(8 - k) : 14'h1007,
                 3'((k < 8) ? 7 - k : 0), 1, 0, 1, (k == 8));
        end
        clr = 1;
        step("clr_err", 14'h1008, 0, 1, 0, 0, 0);
        ret = 1; clr = 1;
        step("unf_beats_clr", 14'h0507, 0, 1, 0, 0, 1);
        clr = 1;
        step("clr_unf", 14'h0508, 0, 1, 0, 0, 0);
        step("unf_fl3", 14'h0509, 0, 1, 0, 0, 0);
        step("unf_run", 14'h050A, 0, 0, 0, 0, 0);

        // Wrap and stall
        jmp = 1; target = 14'h3FFF;
        step("jmp_3fff", 14'h3FFF, 0, 1, 0, 0, 0);
        step("wrap", 14'h0000, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            stall = 1;
            step("stall_hold", 14'h0000, 0, (i == 0), 0, 0, 0);
        end
        stall = 1; jmp = 1; target = 14'h0ABC;
        step("stall_jmp", 14'h0ABC, 0, 1, 0, 0, 0);
        stall = 1;
        step("stall_hold2", 14'h0ABC, 0, 1, 0, 0, 0);

        // Halt / wake / reset
        halt = 1; jmp = 1; target = 14'h0222;
        step("halt_vs_jmp", 14'h0222, 0, 1, 0, 0, 0);
        halt = 1;
        step("halt", 14'h0222, 0, 0, 1, 0, 0);
        jmp = 1; target = 14'h0111;
        step("halt_jmp_ign", 14'h0222, 0, 0, 1, 0, 0);
        call = 1; target = 14'h0333;
        step("halt_call_ign", 14'h0222, 0, 0, 1, 0, 0);
        halt = 1; wake = 1;
        step("halt_wake_both", 14'h0222, 0, 0, 1, 0, 0);
        wake = 1;
        step("wake", 14'h0222, 0, 1, 0, 0, 0);
        step("wake_fl2", 14'h0223, 0, 1, 0, 0, 0);
        rst_n = 1'b0;
        check_now("rst_mid_flush", 14'h0000, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_now("rst_rel2", 14'h0000, 0, 0, 0, 0, 0);
        step("first_inc", 14'h0001, 0, 0, 0, 0, 0);
        step("second_inc", 14'h0002, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0",
                     q.size());
            n_bad += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
